// File: rtl/sprite_blitter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// sprite_blitter : double-buffered, scalable, mirrorable sprite over background
// Rev 1.0
// ============================================================================
module sprite_blitter #(
  parameter int SPR_W      = 20,
  parameter int SPR_H      = 20,
  parameter int SCALE_SH   = 0,
  parameter int IDX_W      = 4,
  parameter int TRANSP_IDX = 0,
  parameter int ADDR_W     = 9
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              pos_we,
  input  logic              flip_h,
  input  logic              sprite_en,
  input  logic [3:0]        bg_red,
  input  logic [3:0]        bg_green,
  input  logic [3:0]        bg_blue,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic [15:0]       hit_count
);

  localparam int              BW         = SPR_W << SCALE_SH;
  localparam int              BH         = SPR_H << SCALE_SH;
  localparam logic [10:0]     C_BW       = 11'(BW);
  localparam logic [10:0]     C_BH       = 11'(BH);
  localparam logic [9:0]      C_SPR_W_M1 = 10'(SPR_W - 1);
  localparam logic [IDX_W-1:0] C_TRANSP  = IDX_W'(TRANSP_IDX);

  // Shadow (written by pos_we) and active (used for rendering) registers
  logic [9:0]  r_sh_x, r_sh_y, r_ax, r_ay;
  logic        r_sh_flip, r_flip;

  logic        r_hit_d1, r_blank_d1;
  logic [11:0] r_bg_d1;
  logic [3:0]  r_red, r_green, r_blue;
  logic [15:0] r_cnt, r_hit_count;

  logic [10:0]       w_x_end, w_y_end;
  logic              w_hit;
  logic [9:0]        w_dx, w_dy, w_lx, w_ly, w_lxf;
  logic [ADDR_W-1:0] w_addr;
  logic              w_opaque, w_count_inc;
  logic [15:0]       w_cnt_next;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_sh_x    <= '0;
      r_sh_y    <= '0;
      r_sh_flip <= 1'b0;
      r_ax      <= '0;
      r_ay      <= '0;
      r_flip    <= 1'b0;
    end else begin
      if (pos_we) begin
        r_sh_x    <= pos_x;
        r_sh_y    <= pos_y;
        r_sh_flip <= flip_h;
      end
      // Reads the pre-write shadow, so a coincident pos_we lands next frame
      if (frame_start) begin
        r_ax   <= r_sh_x;
        r_ay   <= r_sh_y;
        r_flip <= r_sh_flip;
      end
    end
  end

  // 11-bit bounds so a box running past x/y = 1023 clips instead of wrapping
  assign w_x_end = {1'b0, r_ax} + C_BW;
  assign w_y_end = {1'b0, r_ay} + C_BH;
  assign w_hit   = sprite_en
                 && (DrawX >= r_ax) && ({1'b0, DrawX} < w_x_end)
                 && (DrawY >= r_ay) && ({1'b0, DrawY} < w_y_end);

  assign w_dx   = DrawX - r_ax;
  assign w_dy   = DrawY - r_ay;
  assign w_lx   = w_dx >> SCALE_SH;
  assign w_ly   = w_dy >> SCALE_SH;
  assign w_lxf  = r_flip ? (C_SPR_W_M1 - w_lx) : w_lx;
  assign w_addr = ADDR_W'(w_ly) * ADDR_W'(SPR_W) + ADDR_W'(w_lxf);

  assign rom_addr  = w_hit ? w_addr : '0;
  assign pal_index = rom_q;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_hit_d1   <= 1'b0;
      r_blank_d1 <= 1'b0;
      r_bg_d1    <= '0;
    end else begin
      r_hit_d1   <= w_hit;
      r_blank_d1 <= blank;
      r_bg_d1    <= {bg_red, bg_green, bg_blue};
    end
  end

  // rom_q is only consulted behind r_hit_d1, keeping the output X-free
  assign w_opaque    = r_hit_d1 && (rom_q != C_TRANSP);
  assign w_count_inc = r_blank_d1 && w_opaque;
  assign w_cnt_next  = (w_count_inc && (r_cnt != 16'hFFFF)) ? (r_cnt + 16'd1) : r_cnt;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_red       <= '0;
      r_green     <= '0;
      r_blue      <= '0;
      r_cnt       <= '0;
      r_hit_count <= '0;
    end else begin
      if (!r_blank_d1) begin
        r_red   <= '0;
        r_green <= '0;
        r_blue  <= '0;
      end else if (w_opaque) begin
        r_red   <= pal_red;
        r_green <= pal_green;
        r_blue  <= pal_blue;
      end else begin
        r_red   <= r_bg_d1[11:8];
        r_green <= r_bg_d1[7:4];
        r_blue  <= r_bg_d1[3:0];
      end
      if (frame_start) begin
        r_hit_count <= w_cnt_next;
        r_cnt       <= '0;
      end else begin
        r_cnt <= w_cnt_next;
      end
    end
  end

  assign red       = r_red;
  assign green     = r_green;
  assign blue      = r_blue;
  assign hit_count = r_hit_count;

endmodule
`default_nettype wire

// File: tb/tb_sprite_blitter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_sprite_blitter : scoreboard bench, default instance plus a 2x mirrored one
// Rev 1.0
// ============================================================================
module tb_sprite_blitter;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic [9:0]  DrawX, DrawY;
  logic        blank, sprite_en;
  logic [3:0]  bg_red, bg_green, bg_blue;

  logic        frame_start0, pos_we0, flip0;
  logic [9:0]  pos_x0, pos_y0;
  logic [8:0]  rom_addr0;
  logic [3:0]  rom_q0, pal_index0, red0, green0, blue0;
  logic [15:0] hit_count0;

  logic        frame_start1, pos_we1, flip1;
  logic [9:0]  pos_x1, pos_y1;
  logic [8:0]  rom_addr1;
  logic [3:0]  rom_q1, pal_index1, red1, green1, blue1;
  logic [15:0] hit_count1;

  logic [3:0]  mem [0:511];

  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) begin
    rom_q0 <= mem[rom_addr0];
    rom_q1 <= mem[rom_addr1];
  end

  sprite_blitter u_dut0 (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .frame_start(frame_start0), .pos_x(pos_x0), .pos_y(pos_y0),
    .pos_we(pos_we0), .flip_h(flip0), .sprite_en(sprite_en),
    .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .rom_addr(rom_addr0), .rom_q(rom_q0), .pal_index(pal_index0),
    .pal_red(pal_index0), .pal_green(~pal_index0), .pal_blue(pal_index0 ^ 4'h5),
    .red(red0), .green(green0), .blue(blue0), .hit_count(hit_count0)
  );

  sprite_blitter #(.SCALE_SH(1)) u_dut1 (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .frame_start(frame_start1), .pos_x(pos_x1), .pos_y(pos_y1),
    .pos_we(pos_we1), .flip_h(flip1), .sprite_en(sprite_en),
    .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .rom_addr(rom_addr1), .rom_q(rom_q1), .pal_index(pal_index1),
    .pal_red(pal_index1), .pal_green(~pal_index1), .pal_blue(pal_index1 ^ 4'h5),
    .red(red1), .green(green1), .blue(blue1), .hit_count(hit_count1)
  );

  // kinds: 0 rgb0, 1 addr0, 2 hit_count0, 3 addr1, 4 rgb1, 5 hit_count1
  typedef struct {
    int          due;
    int          kind;
    logic [15:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_bad  = 0;

  always @(posedge vga_clk) cyc <= cyc + 1;

  always @(negedge vga_clk) begin
    logic [15:0] act;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].due <= cyc) begin
        case (q[i].kind)
          0:       act = {4'h0, red0, green0, blue0};
          1:       act = 16'(rom_addr0);
          2:       act = hit_count0;
          3:       act = 16'(rom_addr1);
          4:       act = {4'h0, red1, green1, blue1};
          default: act = hit_count1;
        endcase
        n_vec++;
        if (q[i].due < cyc) begin
          n_bad++;
          $display("FAIL %s: check missed at cycle %0d (due %0d)", q[i].name, cyc, q[i].due);
        end else if (act !== q[i].exp) begin
          n_bad++;
          $display("FAIL %s: got %h, expected %h (cycle %0d)", q[i].name, act, q[i].exp, cyc);
        end
        q.delete(i);
      end
    end
  end

  task automatic exp_chk(input int dly, input int kind, input logic [15:0] e, input string nm);
    chk_t c;
    c.due  = cyc + dly;
    c.kind = kind;
    c.exp  = e;
    c.name = nm;
    q.push_back(c);
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic pix(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
  endtask

  task automatic set_pos0(input int x, input int y);
    pos_x0 = 10'(x); pos_y0 = 10'(y); pos_we0 = 1'b1;
    tick();
    pos_we0 = 1'b0;
  endtask

  task automatic fs0();
    frame_start0 = 1'b1;
    tick();
    frame_start0 = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 512; a++) mem[a] = 4'h7;
    reset = 1'b1; DrawX = '0; DrawY = '0; blank = 1'b1; sprite_en = 1'b0;
    bg_red = 4'hA; bg_green = 4'hB; bg_blue = 4'hC;
    frame_start0 = 0; pos_we0 = 0; flip0 = 0; pos_x0 = '0; pos_y0 = '0;
    frame_start1 = 0; pos_we1 = 0; flip1 = 0; pos_x1 = '0; pos_y1 = '0;
    tick(); tick();
    exp_chk(0, 0, 16'h0000, "rst_rgb0");
    exp_chk(0, 2, 16'h0000, "rst_hc0");
    exp_chk(0, 5, 16'h0000, "rst_hc1");
    tick();
    reset = 1'b0;

    // after reset both instances render at (0,0)
    sprite_en = 1'b1;
    pix(5, 3);
    exp_chk(0, 1, 16'd65, "post_rst_addr0");
    exp_chk(0, 3, 16'd22, "post_rst_addr1");
    exp_chk(2, 0, 16'h0782, "post_rst_rgb0");
    tick();

    // 2x scaled, mirrored instance at (0,0)
    pos_x1 = '0; pos_y1 = '0; flip1 = 1'b1; pos_we1 = 1'b1;
    tick();
    pos_we1 = 1'b0; flip1 = 1'b0; frame_start1 = 1'b1;
    tick();
    frame_start1 = 1'b0;
    pix(3, 5);   exp_chk(0, 3, 16'd58,  "flip_addr1");  exp_chk(2, 4, 16'h0782, "flip_rgb1"); tick();
    pix(40, 5);  exp_chk(0, 3, 16'd0,   "outside_addr1"); exp_chk(2, 4, 16'h0ABC, "outside_rgb1"); tick();
    pix(39, 39); exp_chk(0, 3, 16'd380, "corner_addr1"); tick();
    pix(0, 0);   exp_chk(0, 3, 16'd19,  "origin_addr1"); tick();

    // default instance at (100,50)
    set_pos0(100, 50);
    fs0();
    mem[65] = 4'h9;
    mem[66] = 4'h0;
    pix(105, 53); exp_chk(0, 1, 16'd65, "basic_addr"); exp_chk(2, 0, 16'h096C, "basic_rgb"); tick();
    pix(106, 53); exp_chk(0, 1, 16'd66, "transp_addr"); exp_chk(2, 0, 16'h0ABC, "transp_rgb"); tick();
    blank = 1'b0;
    pix(105, 53); exp_chk(2, 0, 16'h0000, "blank_rgb"); tick();
    blank = 1'b1;
    pix(100, 50); exp_chk(0, 1, 16'd0,   "tl_addr");  exp_chk(2, 0, 16'h0782, "tl_rgb"); tick();
    pix(119, 69); exp_chk(0, 1, 16'd399, "br_addr");  exp_chk(2, 0, 16'h0782, "br_rgb"); tick();
    bg_red = 4'h1; bg_green = 4'h2; bg_blue = 4'h3;
    pix(120, 53); exp_chk(0, 1, 16'd0, "right_addr"); exp_chk(2, 0, 16'h0123, "right_rgb"); tick();
    pix(105, 70); exp_chk(2, 0, 16'h0123, "below_rgb"); tick();
    pix(99, 53);  exp_chk(2, 0, 16'h0123, "left_rgb"); tick();
    bg_red = 4'hA; bg_green = 4'hB; bg_blue = 4'hC;
    sprite_en = 1'b0;
    pix(105, 53); exp_chk(0, 1, 16'd0, "dis_addr"); exp_chk(2, 0, 16'h0ABC, "dis_rgb"); tick();
    sprite_en = 1'b1;

    // double buffering
    set_pos0(200, 10);
    pix(105, 53); exp_chk(0, 1, 16'd65, "shadow_only_addr"); tick();
    frame_start0 = 1'b1;
    pix(205, 13); exp_chk(0, 1, 16'd0, "fs_cycle_addr"); tick();
    frame_start0 = 1'b0;
    pix(205, 13); exp_chk(0, 1, 16'd65, "after_fs_addr"); tick();
    pix(105, 53); exp_chk(0, 1, 16'd0, "old_pos_addr"); tick();
    set_pos0(300, 100);
    pos_x0 = 10'd400; pos_y0 = 10'd200; pos_we0 = 1'b1; frame_start0 = 1'b1;
    tick();
    pos_we0 = 1'b0; frame_start0 = 1'b0;
    pix(305, 103); exp_chk(0, 1, 16'd65, "coinc_old_addr"); tick();
    pix(405, 203); exp_chk(0, 1, 16'd0,  "coinc_new_addr"); tick();
    fs0();
    pix(405, 203); exp_chk(0, 1, 16'd65, "next_fs_addr"); tick();

    // right-edge clipping, no wrap to x=0
    set_pos0(630, 0);
    fs0();
    pix(630, 0);  exp_chk(2, 0, 16'h0782, "edge630_rgb"); tick();
    pix(639, 0);  exp_chk(0, 1, 16'd9, "edge639_addr"); exp_chk(2, 0, 16'h0782, "edge639_rgb"); tick();
    pix(5, 0);    exp_chk(0, 1, 16'd0, "nowrap5_addr"); exp_chk(2, 0, 16'h0ABC, "nowrap5_rgb"); tick();
    pix(0, 0);    exp_chk(2, 0, 16'h0ABC, "nowrap0_rgb"); tick();
    pix(639, 19); exp_chk(0, 1, 16'd389, "edge_bot_addr"); tick();
    pix(639, 20); exp_chk(0, 1, 16'd0, "edge_below_addr"); tick();

    // full opaque 20x20 frame; closing frame_start shares the last increment
    mem[66] = 4'h7;
    sprite_en = 1'b0;
    tick(); tick();
    set_pos0(0, 0);
    fs0();
    sprite_en = 1'b1;
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 20; x++) begin
        pix(x, y);
        tick();
      end
    sprite_en = 1'b0;
    frame_start0 = 1'b1;
    exp_chk(1, 2, 16'd400, "hit_count_400");
    tick();
    frame_start0 = 1'b0;

    // mid-line reset
    sprite_en = 1'b1;
    pix(5, 3); exp_chk(2, 0, 16'h096C, "pre_rst_rgb"); tick();
    pix(6, 3); tick();
    reset = 1'b1;
    pix(7, 3);
    exp_chk(1, 0, 16'h0000, "mid_rst_rgb");
    exp_chk(1, 2, 16'h0000, "mid_rst_hc");
    exp_chk(2, 0, 16'h0000, "rst_flush_rgb");
    tick();
    reset = 1'b0;
    pix(5, 3); exp_chk(0, 1, 16'd65, "rst_origin_addr"); exp_chk(2, 0, 16'h096C, "rst_origin_rgb"); tick();

    for (int k = 0; k < 20 && q.size() > 0; k++) tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
